ling_add_arbiter: RTL and testbench

LING_ADD_ARBITER -- requirements
Module: ling_add_arbiter

---
 rtl/ling_add_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ling_add_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ling_add_arbiter.sv
// ling_add_arbiter: N_REQ requesters share one registered 32-bit Ling adder.
// Round-robin grant, valid/ready on both sides, 1-cycle latency, 1 op/cycle.
// Ports: clk_i, rst_i (sync, active-high); req_valid_i/req_a_i/req_b_i/
//   req_cin_i in, req_ready_o out; rsp_valid_o/rsp_sum_o/rsp_cout_o/
//   rsp_id_o out, rsp_ready_i in.
// Macro LING_ARB_CHAIN_EN: adds req_chain_i and an ARB/LOCK FSM so one
//   requester can issue a multi-word add with carry passed between beats.
module ling_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [32*N_REQ-1:0]   req_a_i,
    input  logic [32*N_REQ-1:0]   req_b_i,
    input  logic [N_REQ-1:0]      req_cin_i,
`ifdef LING_ARB_CHAIN_EN
    input  logic [N_REQ-1:0]      req_chain_i,
`endif
    output logic [N_REQ-1:0]      req_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_sum_o,
    output logic                  rsp_cout_o,
    output logic [ID_W-1:0]       rsp_id_o
);

    // Ling adder: H_i = g_i | t_{i-1} H_{i-1}, carry c_{i+1} = t_i & H_i.
    // H is computed with a Kogge-Stone prefix over (g_i, t_{i-1}) pairs;
    // cin enters as part of H_0 since g_0 implies t_0.
    function automatic logic [32:0] ling_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        cin
    );
        logic [31:0] t;
        logic [31:0] p;
        logic [31:0] hg;
        logic [31:0] hp;
        logic [31:0] c;
        t  = a | b;
        p  = a ^ b;
        hg = a & b;
        hg[0] = hg[0] | cin;
        hp = {t[30:0], 1'b0};
        for (int d = 1; d < 32; d = d * 2) begin
            // descending so hg[i-d] is still the previous level's value
            for (int i = 31; i >= d; i--) begin
                hg[i] = hg[i] | (hp[i] & hg[i-d]);
                hp[i] = hp[i] & hp[i-d];
            end
        end
        c = {t[30:0] & hg[30:0], cin};
        return {t[31] & hg[31], p ^ c};
    endfunction

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

`ifdef LING_ARB_CHAIN_EN
    typedef enum logic {ARB, LOCK} state_e;
    state_e           state_q, state_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic             chain_c_q, chain_c_d;
`endif

    logic             found;
    logic [ID_W-1:0]  gnt_id;
    logic             slot_free;
    logic             accept;
    logic [31:0]      a_sel;
    logic [31:0]      b_sel;
    logic             cin_sel;
    logic [32:0]      res;

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
`ifdef LING_ARB_CHAIN_EN
        // a locked requester owns the adder even while it is idle
        if (state_q == LOCK) begin
            found  = req_valid_i[lock_id_q];
            gnt_id = lock_id_q;
        end
`endif
    end

    assign slot_free   = !rsp_valid_q || rsp_ready_i;
    assign req_ready_o = (found && slot_free && !rst_i) ?
                         (N_REQ'(1) << gnt_id) : '0;
    assign accept      = |req_ready_o;

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                a_sel = req_a_i[32*k +: 32];
                b_sel = req_b_i[32*k +: 32];
            end
        end
        cin_sel = req_cin_i[gnt_id];
`ifdef LING_ARB_CHAIN_EN
        if (state_q == LOCK) cin_sel = chain_c_q;
`endif
        res = ling_add(a_sel, b_sel, cin_sel);
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        if (slot_free) rsp_valid_d = accept;
        if (accept) begin
            rsp_sum_d  = res[31:0];
            rsp_cout_d = res[32];
            rsp_id_d   = gnt_id;
            ptr_d      = ID_W'((int'(gnt_id) + 1) % N_REQ);
        end
`ifdef LING_ARB_CHAIN_EN
        state_d   = state_q;
        lock_id_d = lock_id_q;
        chain_c_d = chain_c_q;
        if (accept) begin
            chain_c_d = res[32];
            unique case (state_q)
                ARB: begin
                    if (req_chain_i[gnt_id]) begin
                        state_d   = LOCK;
                        lock_id_d = gnt_id;
                    end
                end
                LOCK: begin
                    if (!req_chain_i[gnt_id]) state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
`ifdef LING_ARB_CHAIN_EN
            state_q     <= ARB;
            lock_id_q   <= '0;
            chain_c_q   <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
`ifdef LING_ARB_CHAIN_EN
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            chain_c_q   <= chain_c_d;
`endif
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_ling_add_arbiter.sv
// tb_ling_add_arbiter: directed + constrained-random bench for the shared
// Ling adder arbiter, with a reference grant model and response scoreboard.
module tb_ling_add_arbiter;

    localparam int N = 4;
    localparam int W = 2;
`ifdef LING_ARB_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid;
    logic [32*N-1:0] a;
    logic [32*N-1:0] b;
    logic [N-1:0]   cin;
    logic [N-1:0]   chain;
    logic [N-1:0]   ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_sum;
    logic           rsp_cout;
    logic [W-1:0]   rsp_id;

    always #5 clk = ~clk;

    ling_add_arbiter #(.N_REQ(N), .ID_W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_a_i     (a),
        .req_b_i     (b),
        .req_cin_i   (cin),
`ifdef LING_ARB_CHAIN_EN
        .req_chain_i (chain),
`endif
        .req_ready_o (ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum),
        .rsp_cout_o  (rsp_cout),
        .rsp_id_o    (rsp_id)
    );

    typedef struct packed {
        logic [W-1:0] id;
        logic         cout;
        logic [31:0]  sum;
    } rsp_t;

    rsp_t         sb[$];
    int           vectors;
    int           miscompares;
    logic [W-1:0] mptr;
    logic         mvalid;
    logic         mlock;
    logic [W-1:0] mlock_id;
    logic         mchain_c;
    logic         post_rst;
    int           last_acc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] av,
                          input logic [31:0] bv, input logic c,
                          input logic ch);
        a[32*k +: 32] = av;
        b[32*k +: 32] = bv;
        cin[k]        = c;
        chain[k]      = ch;
    endtask

    task automatic tick(input string tag);
        logic [N-1:0] eg;
        logic         sf;
        logic         ci;
        logic [32:0]  s;
        int           k;
        #1;
        sf = !mvalid || rsp_ready;
        eg = '0;
        k  = -1;
        if (!rst && sf) begin
            if (mlock) begin
                if (valid[mlock_id]) k = int'(mlock_id);
            end else begin
                for (int i = 0; i < N; i++) begin
                    int idx;
                    idx = (int'(mptr) + i) % N;
                    if (k < 0 && valid[idx]) k = idx;
                end
            end
            if (k >= 0) eg[k] = 1'b1;
        end
        chk({tag, ".ready"}, 64'(ready), 64'(eg));
        last_acc = k;
        if (rst) begin
            sb.delete();
            mvalid   = 1'b0;
            mptr     = '0;
            mlock    = 1'b0;
            mchain_c = 1'b0;
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
            if (mvalid && rsp_ready && sb.size() > 0) void'(sb.pop_front());
            if (k >= 0) begin
                ci = mlock ? mchain_c : cin[k];
                s  = {1'b0, a[32*k +: 32]} + {1'b0, b[32*k +: 32]} + 33'(ci);
                sb.push_back({W'(k), s[32], s[31:0]});
                mvalid = 1'b1;
                mptr   = W'((k + 1) % N);
                if (CHAIN) begin
                    mchain_c = s[32];
                    if (!mlock && chain[k]) begin
                        mlock    = 1'b1;
                        mlock_id = W'(k);
                    end else if (mlock && !chain[k]) begin
                        mlock = 1'b0;
                    end
                end
            end else if (sf) begin
                mvalid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(mvalid));
        if (post_rst) begin
            chk({tag, ".rst_sum"}, 64'(rsp_sum), 64'd0);
            chk({tag, ".rst_cout"}, 64'(rsp_cout), 64'd0);
            chk({tag, ".rst_id"}, 64'(rsp_id), 64'd0);
        end else if (mvalid) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                chk({tag, ".id"}, 64'(rsp_id), 64'(sb[0].id));
                chk({tag, ".cout"}, 64'(rsp_cout), 64'(sb[0].cout));
                chk({tag, ".sum"}, 64'(rsp_sum), 64'(sb[0].sum));
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_op(input int k);
        set_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mptr        = '0;
        mvalid      = 1'b0;
        mlock       = 1'b0;
        mlock_id    = '0;
        mchain_c    = 1'b0;
        post_rst    = 1'b0;
        last_acc    = -1;
        rst         = 1'b1;
        valid       = '1;
        rsp_ready   = 1'b1;
        cin         = '0;
        chain       = '0;
        for (int k = 0; k < N; k++) rand_op(k);
        @(negedge clk);

        tick("rst0");
        tick("rst1");

        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick("rr");
            chk("rr_order", 64'(last_acc), 64'(n % N));
            if (last_acc >= 0) rand_op(last_acc);
        end

        valid = 4'b0100;
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        tick("arith");
        chk("arith_sum", 64'(rsp_sum), 64'd0);
        chk("arith_cout", 64'(rsp_cout), 64'd1);
        chk("arith_id", 64'(rsp_id), 64'd2);

        valid = 4'b0001;
        set_op(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        tick("cin_wrap");
        chk("cin_wrap_sum", 64'(rsp_sum), 64'd0);
        chk("cin_wrap_cout", 64'(rsp_cout), 64'd1);

        valid = 4'b0010;
        set_op(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        tick("no_cout");
        chk("no_cout_sum", 64'(rsp_sum), 64'h8000_0000);
        chk("no_cout_cout", 64'(rsp_cout), 64'd0);

        valid = '0;
        tick("idle");

        valid = 4'b1111;
        tick("bp_load");
        if (last_acc >= 0) rand_op(last_acc);
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) tick("bp_hold");
        rsp_ready = 1'b1;
        tick("bp_rel");
        if (last_acc >= 0) rand_op(last_acc);
        valid = '0;
        tick("bp_drain");

        for (int n = 0; n < 40; n++) begin
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            tick("rand");
            if (last_acc >= 0) begin
                valid[last_acc] = 1'($urandom_range(0, 1));
                rand_op(last_acc);
            end
            for (int k = 0; k < N; k++) begin
                if (!valid[k] && $urandom_range(0, 1) == 1) begin
                    rand_op(k);
                    valid[k] = 1'b1;
                end
            end
        end
        rsp_ready = 1'b1;
        valid     = '0;
        tick("rand_drain");

`ifdef LING_ARB_CHAIN_EN
        rst = 1'b1;
        tick("ch_rst");
        rst   = 1'b0;
        valid = 4'b1010;
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        set_op(3, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        tick("ch_lo");
        chk("ch_lo_sum", 64'(rsp_sum), 64'd0);
        chk("ch_lo_id", 64'(rsp_id), 64'd1);
        set_op(1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        valid = 4'b1000;
        tick("ch_gap");
        chk("ch_gap_grant", 64'(last_acc), -64'sd1);
        valid = 4'b1010;
        tick("ch_hi");
        chk("ch_hi_sum", 64'(rsp_sum), 64'd2);
        chk("ch_hi_id", 64'(rsp_id), 64'd1);
        valid = 4'b1000;
        tick("ch_next");
        chk("ch_next_id", 64'(rsp_id), 64'd3);
        valid = '0;
        tick("ch_idle");

        valid = 4'b0010;
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        tick("rl_lo");
        rst = 1'b1;
        tick("rl_rst");
        rst   = 1'b0;
        valid = 4'b1011;
        chain = '0;
        #1;
        chk("rl_grant", 64'(ready), 64'b0001);
        tick("rl_after");
        valid = '0;
        tick("rl_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
